// File: rtl/exec_mem_reg.sv
// exec_mem_reg -- execute-to-memory pipeline register of the pipelined Y86-64 core.
//
// Purpose:
//   Captures the execute-stage results (stat, icode, cnd, valE, valA, dstE, dstM)
//   and presents them to the memory stage one cycle later. Also owns the
//   architectural condition-code register: execute reads cc and returns cc_new,
//   and this block decides whether that value is committed.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall_m, bubble_m   pipeline control (stall holds, bubble inserts a nop)
//   e_*                 execute-stage results to be registered
//   cc_new              CC computed by execute: [0]=ZF, [1]=SF, [2]=OF
//   m_stat_now, w_stat  status of the instructions now in M and W (CC gating)
//   cc                  architectural CC {OF,SF,ZF}
//   M_*                 registered memory-stage values
//
// There are no handshakes and no FSM: every output is a plain register.
module exec_mem_reg #(
  parameter int unsigned WIDTH     = 64,
  parameter logic [3:0]  RNONE     = 4'hF,
  parameter logic [3:0]  NOP_ICODE = 4'h1,
  parameter logic [2:0]  CC_RESET  = 3'b001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_m,
  input  logic             bubble_m,
  input  logic [2:0]       e_stat,
  input  logic [3:0]       e_icode,
  input  logic             e_cnd,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic [2:0]       cc_new,
  input  logic [2:0]       m_stat_now,
  input  logic [2:0]       w_stat,
  output logic [2:0]       cc,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [2:0] STAT_AOK  = 3'd1;
  localparam logic [2:0] STAT_HLT  = 3'd2;
  localparam logic [2:0] STAT_ADR  = 3'd3;
  localparam logic [2:0] STAT_INS  = 3'd4;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;

  logic [2:0]       stat_q,  stat_d;
  logic [3:0]       icode_q, icode_d;
  logic             cnd_q,   cnd_d;
  logic [WIDTH-1:0] vale_q,  vale_d;
  logic [WIDTH-1:0] vala_q,  vala_d;
  logic [3:0]       dste_q,  dste_d;
  logic [3:0]       dstm_q,  dstm_d;
  logic [2:0]       cc_q,    cc_d;

  logic m_exc;
  logic w_exc;
  logic set_cc;

  // An excepting instruction already in M or W freezes CC so that no younger
  // OPq can change architectural state after the fault.
  assign m_exc  = (m_stat_now == STAT_HLT) || (m_stat_now == STAT_ADR) ||
                  (m_stat_now == STAT_INS);
  assign w_exc  = (w_stat == STAT_HLT) || (w_stat == STAT_ADR) ||
                  (w_stat == STAT_INS);
  assign set_cc = (e_icode == ICODE_OPQ) && !reset && !stall_m && !m_exc && !w_exc;

  // Next-state for the M registers: stall > bubble > load. Reset is applied in
  // the register process so it overrides everything, including X inputs.
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    if (!stall_m) begin
      if (bubble_m) begin
        stat_d  = STAT_AOK;
        icode_d = NOP_ICODE;
        cnd_d   = 1'b0;
        vale_d  = '0;
        vala_d  = '0;
        dste_d  = RNONE;
        dstm_d  = RNONE;
      end else begin
        stat_d  = e_stat;
        icode_d = e_icode;
        cnd_d   = e_cnd;
        vale_d  = e_valE;
        vala_d  = e_valA;
        // A cmov whose condition failed must not write its destination.
        // rrmovq shares the icode but always arrives with cnd=1.
        dste_d  = ((e_icode == ICODE_CMOV) && !e_cnd) ? RNONE : e_dstE;
        dstm_d  = e_dstM;
      end
    end
  end

  // CC is independent of bubble_m: an OPq in E commits even while M bubbles.
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = cc_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q  <= STAT_AOK;
      icode_q <= NOP_ICODE;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
      cc_q    <= CC_RESET;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      cc_q    <= cc_d;
    end
  end

  assign cc      = cc_q;
  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_exec_mem_reg.sv
module tb_exec_mem_reg;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, stall_m, bubble_m, e_cnd;
  logic [2:0]    e_stat, cc_new, m_stat_now, w_stat;
  logic [3:0]    e_icode, e_dstE, e_dstM;
  logic [W-1:0]  e_valE, e_valA;
  logic [2:0]    cc, M_stat;
  logic [3:0]    M_icode, M_dstE, M_dstM;
  logic          M_cnd;
  logic [W-1:0]  M_valE, M_valA;

  exec_mem_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .stall_m(stall_m), .bubble_m(bubble_m),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM), .cc_new(cc_new),
    .m_stat_now(m_stat_now), .w_stat(w_stat), .cc(cc), .M_stat(M_stat),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   dste;
    logic [3:0]   dstm;
    logic [2:0]   cc;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   driver_done = 0;

  function automatic exp_t nop_slot(input logic [2:0] keep_cc);
    exp_t r;
    r.stat = 3'd1; r.icode = 4'h1; r.cnd = 1'b0; r.vale = '0; r.vala = '0;
    r.dste = 4'hF; r.dstm = 4'hF; r.cc = keep_cc;
    return r;
  endfunction

  function automatic bit is_exception(input logic [2:0] s);
    return s inside {3'd2, 3'd3, 3'd4};
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs on the falling edge, predicts what M and cc
  // must show after the next rising edge, and queues that prediction.
  task automatic step(input logic rst, input logic stl, input logic bub,
                      input logic [2:0] es, input logic [3:0] ic, input logic cd,
                      input logic [W-1:0] ve, input logic [W-1:0] va,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic [2:0] ccn, input logic [2:0] ms, input logic [2:0] ws);
    exp_t nx;
    @(negedge clk);
    reset = rst; stall_m = stl; bubble_m = bub; e_stat = es; e_icode = ic;
    e_cnd = cd; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
    cc_new = ccn; m_stat_now = ms; w_stat = ws;
    nx = model;
    if (rst) begin
      nx = nop_slot(3'b001);
    end else begin
      if (stl) begin
        // everything in M holds
      end else if (bub) begin
        nx = nop_slot(model.cc);
      end else begin
        nx.stat = es; nx.icode = ic; nx.cnd = cd; nx.vale = ve; nx.vala = va;
        nx.dstm = dm;
        nx.dste = (ic == 4'h2 && cd == 1'b0) ? 4'hF : de;
      end
      if (ic == 4'h6 && !stl && !is_exception(ms) && !is_exception(ws))
        nx.cc = ccn;
    end
    model = nx;
    exp_q.push_back(nx);
    @(posedge clk);
  endtask

  // Plain load of one instruction with AOK statuses around it.
  task automatic load(input logic [3:0] ic, input logic cd, input logic [W-1:0] ve,
                      input logic [3:0] de, input logic [2:0] ccn);
    step(0, 0, 0, 3'd1, ic, cd, ve, W'($urandom), de, 4'($urandom), ccn, 3'd1, 3'd1);
  endtask

  task automatic rand_inputs_step(input logic rst, input logic stl, input logic bub);
    step(rst, stl, bub, 3'($urandom_range(1, 4)), 4'($urandom), 1'($urandom),
         {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 4'($urandom),
         3'($urandom), 3'd1, 3'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("M_stat",  W'(M_stat),  W'(e.stat));
        chk("M_icode", W'(M_icode), W'(e.icode));
        chk("M_cnd",   W'(M_cnd),   W'(e.cnd));
        chk("M_valE",  M_valE,      e.vale);
        chk("M_valA",  M_valA,      e.vala);
        chk("M_dstE",  W'(M_dstE),  W'(e.dste));
        chk("M_dstM",  W'(M_dstM),  W'(e.dstm));
        chk("cc",      W'(cc),      W'(e.cc));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    model = nop_slot(3'b001);
    // Reset held two cycles with random inputs.
    rand_inputs_step(1, 0, 0);
    rand_inputs_step(1, 1, 1);
    // First load after reset appears one cycle later.
    load(4'h5, 1'b1, 64'h1234, 4'h2, 3'b000);

    // OPq commits cc; irmovq does not.
    load(4'h6, 1'b1, 64'd0,  4'h1, 3'b001);
    load(4'h6, 1'b1, 64'd5,  4'h1, 3'b010);
    load(4'h3, 1'b1, 64'd9,  4'h4, 3'b100);

    // cmov squash and rrmovq/cmov taken.
    load(4'h2, 1'b0, 64'd7, 4'h3, 3'b111);
    load(4'h2, 1'b1, 64'd7, 4'h3, 3'b111);

    // Stall holds, stall+bubble holds, bubble alone inserts a nop.
    load(4'h5, 1'b1, 64'h100, 4'h6, 3'b000);
    repeat (3) step(0, 1, 0, 3'd1, 4'h6, 1'b1, 64'h999, 64'h1, 4'h2, 4'h3, 3'b111, 3'd1, 3'd1);
    step(0, 1, 1, 3'd1, 4'h6, 1'b0, 64'h55, 64'h2, 4'h2, 4'h3, 3'b110, 3'd1, 3'd1);
    step(0, 0, 1, 3'd2, 4'h7, 1'b1, 64'h77, 64'h3, 4'h2, 4'h3, 3'b000, 3'd1, 3'd1);
    // Bubble with OPq in E still commits cc.
    step(0, 0, 1, 3'd1, 4'h6, 1'b1, 64'h77, 64'h3, 4'h2, 4'h3, 3'b011, 3'd1, 3'd1);

    // Exception gating from W, from M, then released.
    step(0, 0, 0, 3'd1, 4'h6, 1'b1, 64'h1, 64'h0, 4'h1, 4'hF, 3'b100, 3'd1, 3'd3);
    step(0, 0, 0, 3'd1, 4'h6, 1'b1, 64'h2, 64'h0, 4'h1, 4'hF, 3'b100, 3'd4, 3'd1);
    step(0, 0, 0, 3'd1, 4'h6, 1'b1, 64'h2, 64'h0, 4'h1, 4'hF, 3'b100, 3'd2, 3'd2);
    step(0, 0, 0, 3'd1, 4'h6, 1'b1, 64'h3, 64'h0, 4'h1, 4'hF, 3'b100, 3'd1, 3'd1);

    // Unknown icode latched unchanged.
    load(4'hE, 1'b0, 64'hDEAD, 4'h7, 3'b010);

    // Mid-stream reset together with stall.
    load(4'h6, 1'b1, 64'h44, 4'h1, 3'b110);
    step(1, 1, 0, 3'd1, 4'h6, 1'b1, 64'h45, 64'h0, 4'h1, 4'hF, 3'b010, 3'd1, 3'd1);

    // Randomized stream.
    for (int i = 0; i < 600; i++) begin
      logic rst, stl, bub;
      rst = ($urandom_range(0, 49) == 0);
      stl = ($urandom_range(0, 5) == 0);
      bub = ($urandom_range(0, 5) == 0);
      step(rst, stl, bub, 3'($urandom_range(1, 4)), 4'($urandom),
           1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           4'($urandom), 4'($urandom), 3'($urandom),
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1,
           ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1);
    end
    driver_done = 1;
  end

  // ---------------- final report ----------------
  initial begin : report
    wait (driver_done);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $finish;
  end

endmodule
